seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes NUM_DIGITS BCD digits onto one shared seven_seg_decoder.
//  Drives the decoder's 4-bit input and the active-low digit anodes.
//  Inserts a dead-time guard (all anodes off) between digits to prevent ghosting.
//  Applies new display values only at frame boundaries (tear-free), and optionally
//  blanks leading zeros.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, 2..8
//  REFRESH_DIV   50000  clk cycles each digit is driven, >=2
//  GUARD_CYCLES  8      clk cycles all anodes off before each digit, >=1
// PORTS
//  clk         in   1             system clock, rising edge
//  reset       in   1             synchronous, active-high
//  load        in   1             1-cycle strobe: value_in is valid
//  value_in    in   4*NUM_DIGITS  BCD digits, digit 0 = [3:0] (LSD)
//  blank_lz    in   1             1 = blank leading zeros (digit 0 is never blanked)
//  digit_code  out  4             to seven_seg_decoder binary_input; 4'hF = blank
//  an          out  NUM_DIGITS    anode enables, active-low, one-hot-low or all 1
//  load_ack    out  1             1-cycle pulse: pending value committed to display
//  frame_done  out  1             1-cycle pulse: last digit finished, index wrapped
// BEHAVIOUR
//  Reset (sync, highest priority, may hit mid-frame or mid-guard): state=GUARD,
//   idx=0, cnt=0, disp=0, pend_v=0, an=all 1, digit_code=4'hF,
//   load_ack=0, frame_done=0.
//  FSM (registered; outputs registered, updated on the same edge as the state):
//   GUARD: an=all 1, digit_code=4'hF. cnt counts 0..GUARD_CYCLES-1.
//     At the last count: cnt<=0, go to DRIVE.
//   DRIVE: an[idx]=0 (others 1), digit_code=disp[idx] or 4'hF if blanked.
//     cnt counts 0..REFRESH_DIV-1. At the last count: cnt<=0, go to GUARD.
//     idx<=idx+1; if idx==NUM_DIGITS-1: idx<=0, frame_done=1, commit.
//  Frame length = NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles.
//  Load/commit:
//   load=1 -> pend<=value_in, pend_v<=1. A later load overwrites (latest wins).
//   Commit (at frame wrap): if load=1 that same cycle, disp<=value_in directly;
//     else if pend_v, disp<=pend. pend_v<=0 and load_ack=1 in the cycle after
//     the commit edge.
//   No pending and no load at wrap -> disp unchanged, load_ack=0.
//   Nibbles >9 are passed through; the decoder blanks them.
//  Leading-zero blank (combinational on disp, registered into digit_code):
//   digit i>0 blanked iff blank_lz=1 and disp digits NUM_DIGITS-1..i are all 0.
//   disp=0 with blank_lz shows a single "0" on digit 0.
//  an is never low on two digits at once and is never low during GUARD.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1; frame=20 cycles)
//  Reset mid-DRIVE of digit 2 -> next cycle an=4'b1111, digit_code=4'hF;
//   digit 0 is driven after 1 guard cycle.
//  load value_in=16'h1234, full frame -> load_ack 1 cycle after wrap;
//   next frame drives an=1110/4,1101/3,1011/2,0111/1 for 4 cycles each,
//   with 1 cycle of 1111 between digits.
//  load 16'h1111, then 16'h5678 mid-frame -> only 16'h5678 is displayed,
//   with exactly one load_ack.
//  load asserted on the wrap cycle with 16'h0009 and pend=16'h1111 ->
//   disp=16'h0009.
//  blank_lz=1, disp=16'h0040 -> digits 3,2 show 4'hF; digit 1=4; digit 0=0.
//   disp=0 -> only digit 0 shows 0.
//  Check every cycle: an has at most one 0; frame_done period is exactly 20
//   cycles.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// Bus between a display-value producer and the seven-segment scan controller.
// The producer drives load/value_in/blank_lz; the controller drives the decoder and anode outputs.
interface seven_seg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value_in;
   logic                      blank_lz;
   logic [3:0]                digit_code;
   logic [NUM_DIGITS-1:0]     an;
   logic                      load_ack;
   logic                      frame_done;

   modport master (
      output load, value_in, blank_lz,
      input  digit_code, an, load_ack, frame_done
   );

   modport slave (
      input  load, value_in, blank_lz,
      output digit_code, an, load_ack, frame_done
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexes NUM_DIGITS BCD digits onto one shared seven-segment decoder with a
// dead-time guard between digits, tear-free frame-boundary updates and leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 8
) (
   input  logic            clk,
   input  logic            reset,
   seven_seg_scan_if.slave bus
);
   localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0]      REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF       = '1;
   localparam logic [3:0]            CODE_BLANK   = 4'hF;

   typedef enum logic {GUARD, DRIVE} state_t;
   typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic                   wrap;

   digits_t                value_in_d;
   digits_t                disp;
   digits_t                pend;
   logic                   pend_v;
   logic [NUM_DIGITS-1:0]  lz_blank;

   logic [NUM_DIGITS-1:0]  an_nxt;
   logic [3:0]             code_nxt;
   logic [NUM_DIGITS-1:0]  an_q;
   logic [3:0]             code_q;
   logic                   load_ack_q;
   logic                   frame_done_q;

   assign value_in_d = bus.value_in;

   // A digit above 0 is blanked while it and every more significant digit are zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_above  = zero_above & (disp[i] == 4'd0);
         lz_blank[i] = bus.blank_lz & zero_above;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      wrap      = 1'b0;
      case (state)
         GUARD: begin
            if (cnt == GUARD_LAST) begin
               cnt_nxt   = '0;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt == REFRESH_LAST) begin
               cnt_nxt   = '0;
               state_nxt = GUARD;
               if (idx == IDX_LAST) begin
                  idx_nxt = '0;
                  wrap    = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = GUARD;
         end
      endcase

      // Outputs follow the state being entered so they change on the same edge.
      an_nxt   = AN_OFF;
      code_nxt = CODE_BLANK;
      if (state_nxt == DRIVE) begin
         an_nxt[idx_nxt] = 1'b0;
         code_nxt        = lz_blank[idx_nxt] ? CODE_BLANK : disp[idx_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= GUARD;
         cnt          <= '0;
         idx          <= '0;
         disp         <= '0;
         pend_v       <= 1'b0;
         an_q         <= AN_OFF;
         code_q       <= CODE_BLANK;
         load_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         an_q         <= an_nxt;
         code_q       <= code_nxt;
         frame_done_q <= wrap;
         load_ack_q   <= wrap & (bus.load | pend_v);
         // A load coinciding with the wrap bypasses the pending register.
         if (wrap) begin
            pend_v <= 1'b0;
            if (bus.load) begin
               disp <= value_in_d;
            end else if (pend_v) begin
               disp <= pend;
            end
         end else if (bus.load) begin
            pend_v <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.load) begin
         pend <= value_in_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.digit_code = code_q;
   assign bus.load_ack   = load_ack_q;
   assign bus.frame_done = frame_done_q;

   a_an_single_low : assert property (@(posedge clk) disable iff (reset)
      $countones(~an_q) <= 1);
   a_guard_dark : assert property (@(posedge clk) disable iff (reset)
      (state == GUARD) |-> (an_q == AN_OFF));
endmodule
